// File: rtl/multiword_add_pkg.sv
// Shared definitions for the nibble-serial multi-word adder.
//   state_t      : sequencer FSM states
//   NIBBLE_W     : width of the shared adder slice
//   cnt_width()  : nibble-counter width for a given operand width
package multiword_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  // clog2 of the nibble count; never below 1 so the counter always exists.
  function automatic int cnt_width(input int width);
    int n;
    n = width / NIBBLE_W;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// 4-bit ripple-carry adder used as the nibble datapath.
//   A, B : nibble operands
//   CI   : carry in
//   S    : nibble sum
//   CO   : carry out of bit 3
module ripple_carry_adder_4bit
  import multiword_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  input  logic                CI,
  output logic [NIBBLE_W-1:0] S,
  output logic                CO
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    S    = '0;
    c[0] = CI;
    for (int i = 0; i < NIBBLE_W; i++) begin
      S[i]     = A[i] ^ B[i] ^ c[i];
      c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
  end

  assign CO = c[NIBBLE_W];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Sequential WIDTH-bit adder/subtractor built on one 4-bit ripple adder,
// processing one nibble per cycle, least-significant nibble first.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake (A, B, CI, SUB)
//   out_valid / out_ready : result handshake (S, CO, OVF)
//   busy                  : operation in progress or result pending
// SUB=1 computes A - B as A + ~B + 1 (CI ignored); CO=1 then means no borrow.
module multiword_add_sequencer
  import multiword_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OVF,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0]    a_reg, b_reg, s_reg;
  logic                carry;
  logic                co_reg, ovf_reg;
  logic [CNT_W-1:0]    idx;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_co;
  logic                last_nib;

  assign last_nib = (state == RUN) && (idx == LAST_IDX);

  ripple_carry_adder_4bit u_nibble_adder (
    .A  (a_reg[NIBBLE_W-1:0]),
    .B  (b_reg[NIBBLE_W-1:0]),
    .CI (carry),
    .S  (nib_sum),
    .CO (nib_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_nib)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Result flops (co_reg, ovf_reg) are separate from the running carry so the
  // visible outputs only move on RUN edges, never on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      s_reg   <= '0;
      carry   <= 1'b0;
      co_reg  <= 1'b0;
      ovf_reg <= 1'b0;
      idx     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= A;
            b_reg <= B ^ {WIDTH{SUB}};
            carry <= SUB ? 1'b1 : CI;
            idx   <= '0;
          end
        end
        RUN: begin
          a_reg <= a_reg >> NIBBLE_W;
          b_reg <= b_reg >> NIBBLE_W;
          s_reg <= {nib_sum, s_reg[WIDTH-1:NIBBLE_W]};
          carry <= nib_co;
          if (last_nib) begin
            // Top nibble: operand sign bits are still in bit 3 before the shift;
            // b_reg already holds the inverted subtrahend.
            co_reg  <= nib_co;
            ovf_reg <= (a_reg[NIBBLE_W-1] == b_reg[NIBBLE_W-1]) &&
                       (nib_sum[NIBBLE_W-1] != a_reg[NIBBLE_W-1]);
          end else begin
            idx <= idx + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign S         = s_reg;
  assign CO        = co_reg;
  assign OVF       = ovf_reg;

endmodule
